// File: rtl/obsidian_alu_pkg.sv
// Shared opcodes, shift selects and FSM state encoding for the Obsidian sequential ALU.
package obsidian_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/obsidian_seq_mul.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle, LSB first,
// WIDTH iterations after start; done flags the last iteration cycle.
module obsidian_seq_mul #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     partial;

    // Upper half accumulates partial sums; lower half starts as the multiplier
    // and is shifted out as its bits are consumed.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(WIDTH - 1);
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
        end else if (busy_q) begin
            acc_d = {partial, acc_q[WIDTH-1:1]};
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/obsidian_alu_seq.sv
// Registered Obsidian ALU with valid/ready handshakes, status flags and a one-entry result register.
// Define OBSIDIAN_ALU_MUL_EN to build the iterative MUL/MULHU path; otherwise those opcodes are reserved.
module obsidian_alu_seq
    import obsidian_alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         alu_control,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   c,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               flag_v,
    output logic               illegal
);

    state_t                  state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        c_q, c_d;
    logic                    z_q, z_d, n_q, n_d, cf_q, cf_d, v_q, v_d, ill_q, ill_d;

    logic [WIDTH:0]          sum_ext, dif_ext;
    logic [2*WIDTH-1:0]      rot_ext;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_c, alu_v, alu_ill, alu_is_mul;

    logic                    accept, load_en;
    logic [WIDTH-1:0]        load_res;
    logic                    load_c, load_v, load_ill;

    assign b_s      = b;
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_ill    = 1'b0;
        alu_is_mul = 1'b0;
        sum_ext    = {1'b0, a} + {1'b0, b};
        dif_ext    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        rot_ext    = {b, b} >> shamt;
        if (alu_control[3:2] == OP_SHIFT) begin
            case (alu_control[1:0])
                SH_SLL: alu_res = b << shamt;
                SH_SRL: alu_res = b >> shamt;
                SH_SRA: alu_res = b_s >>> shamt;
                SH_ROR: alu_res = rot_ext[WIDTH-1:0];
            endcase
        end else begin
            case (alu_control)
                OP_ADD: begin
                    alu_res = sum_ext[WIDTH-1:0];
                    alu_c   = sum_ext[WIDTH];
                    alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    // Carry out of a + ~b + 1 is the no-borrow indication.
                    alu_res = dif_ext[WIDTH-1:0];
                    alu_c   = dif_ext[WIDTH];
                    alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
                end
                OP_OR:  alu_res = a | b;
                OP_XOR: alu_res = a ^ b;
                OP_AND: alu_res = a & b;
`ifdef OBSIDIAN_ALU_MUL_EN
                OP_MUL, OP_MULHU: alu_is_mul = 1'b1;
`endif
                default: alu_ill = 1'b1;
            endcase
        end
    end

`ifdef OBSIDIAN_ALU_MUL_EN
    logic               mul_start, mul_busy, mul_done;
    logic               mul_hi_q, mul_hi_d;
    logic [2*WIDTH-1:0] mul_product;

    obsidian_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        mul_hi_q <= mul_hi_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        load_en     = 1'b0;
        load_res    = alu_res;
        load_c      = alu_c;
        load_v      = alu_v;
        load_ill    = alu_ill;
`ifdef OBSIDIAN_ALU_MUL_EN
        mul_start   = 1'b0;
        mul_hi_d    = mul_hi_q;
`endif
        case (state_q)
            IDLE: begin
                load_en = accept && !alu_is_mul;
`ifdef OBSIDIAN_ALU_MUL_EN
                if (accept && alu_is_mul) begin
                    state_d   = MUL;
                    mul_start = 1'b1;
                    mul_hi_d  = (alu_control == OP_MULHU);
                end
`endif
            end
`ifdef OBSIDIAN_ALU_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_d = LOAD;
                end else if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                // Acceptance required the result register to be free, so load unconditionally.
                load_en  = 1'b1;
                load_res = mul_hi_q ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
                load_c   = 1'b0;
                load_v   = 1'b0;
                load_ill = 1'b0;
                state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        c_d   = c_q;
        z_d   = z_q;
        n_d   = n_q;
        cf_d  = cf_q;
        v_d   = v_q;
        ill_d = ill_q;
        if (load_en) begin
            c_d         = load_res;
            z_d         = (load_res == '0);
            n_d         = load_res[WIDTH-1];
            cf_d        = load_c;
            v_d         = load_v;
            ill_d       = load_ill;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            cf_q        <= 1'b0;
            v_q         <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            cf_q        <= cf_d;
            v_q         <= v_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = cf_q;
    assign flag_v    = v_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_obsidian_alu_seq.sv
// Directed self-checking bench for obsidian_alu_seq at WIDTH=32; expectations follow OBSIDIAN_ALU_MUL_EN.
module tb_obsidian_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        flag_z, flag_n, flag_c, flag_v, illegal;

    int errors = 0;
    int checks = 0;

    logic [31:0] cap_q[$];
    logic        cap_en = 1'b0;

    // Expected field: {c, flag_z, flag_n, flag_c, flag_v, illegal}
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [4:0]  sh;
        logic [36:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    obsidian_alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .illegal     (illegal)
    );

    // A transfer happens on the next rising edge when both are high at the falling edge.
    always @(negedge clk) begin
        if (cap_en && rst_n && out_valid && out_ready) cap_q.push_back(c);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh);
        alu_control = op;
        a           = av;
        b           = bv;
        shamt       = sh;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        alu_control = '0;
        shamt       = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal} !== 38'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int stale;
        out_ready = 1'b0;
        issue(4'b1001, 32'd3, 32'd4, 5'd0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_ready: got %b expected 0", in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal} !== 38'h0) begin
            errors++;
            $display("FAIL mid_reset_state: got %h expected 0",
                     {out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_result: got %0d valid cycles expected 0", stale);
        end
    endtask

    task automatic test_addsub();
        vec_t tbl [5] = '{
            '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, {32'h8000_0000, 5'b01010}},
            '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, {32'h0000_0000, 5'b10100}},
            '{4'b0001, 32'h0000_0005, 32'h0000_0005, 5'd0, {32'h0000_0000, 5'b10100}},
            '{4'b0001, 32'h0000_0000, 32'h0000_0001, 5'd0, {32'hFFFF_FFFF, 5'b01000}},
            '{4'b0001, 32'h8000_0000, 32'h0000_0001, 5'd0, {32'h7FFF_FFFF, 5'b00110}}
        };
        for (int i = 0; i < 5; i++) begin
            issue(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].sh);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL addsub_valid[%0d]: got %b expected 1", i, out_valid);
            end
            checks++;
            if ({c, flag_z, flag_n, flag_c, flag_v, illegal} !== tbl[i].exp) begin
                errors++;
                $display("FAIL addsub[%0d]: got %h expected %h", i,
                         {c, flag_z, flag_n, flag_c, flag_v, illegal}, tbl[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_shift_logic();
        vec_t tbl [11] = '{
            '{4'b0100, 32'h0, 32'h8000_0001, 5'd4, {32'h0000_0010, 5'b00000}},
            '{4'b0101, 32'h0, 32'h8000_0001, 5'd4, {32'h0800_0000, 5'b00000}},
            '{4'b0110, 32'h0, 32'h8000_0001, 5'd4, {32'hF800_0000, 5'b01000}},
            '{4'b0111, 32'h0, 32'h8000_0001, 5'd4, {32'h1800_0000, 5'b00000}},
            '{4'b0100, 32'h0, 32'h8000_0001, 5'd0, {32'h8000_0001, 5'b01000}},
            '{4'b0101, 32'h0, 32'h8000_0001, 5'd0, {32'h8000_0001, 5'b01000}},
            '{4'b0110, 32'h0, 32'h8000_0001, 5'd0, {32'h8000_0001, 5'b01000}},
            '{4'b0111, 32'h0, 32'h8000_0001, 5'd0, {32'h8000_0001, 5'b01000}},
            '{4'b0010, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, {32'hFFF0_12FF, 5'b01000}},
            '{4'b0011, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, {32'hFF00_12CB, 5'b01000}},
            '{4'b1000, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0, {32'h00F0_0034, 5'b00000}}
        };
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].sh);
            checks++;
            if ({out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal} !== {1'b1, tbl[i].exp}) begin
                errors++;
                $display("FAIL shift_logic[%0d]: got %h expected %h", i,
                         {out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal}, {1'b1, tbl[i].exp});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reserved();
`ifdef OBSIDIAN_ALU_MUL_EN
        localparam int NRES = 2;
        vec_t tbl [NRES] = '{
            '{4'b1111, 32'h5, 32'h7, 5'd3, {32'h0, 5'b10001}},
            '{4'b1011, 32'h5, 32'h7, 5'd0, {32'h0, 5'b10001}}
        };
`else
        localparam int NRES = 4;
        vec_t tbl [NRES] = '{
            '{4'b1111, 32'h5, 32'h7, 5'd3, {32'h0, 5'b10001}},
            '{4'b1011, 32'h5, 32'h7, 5'd0, {32'h0, 5'b10001}},
            '{4'b1001, 32'hFFFF_FFFF, 32'h2, 5'd0, {32'h0, 5'b10001}},
            '{4'b1010, 32'hFFFF_FFFF, 32'h2, 5'd0, {32'h0, 5'b10001}}
        };
`endif
        for (int i = 0; i < NRES; i++) begin
            issue(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].sh);
            checks++;
            if ({out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal} !== {1'b1, tbl[i].exp}) begin
                errors++;
                $display("FAIL reserved[%0d]: got %h expected %h", i,
                         {out_valid, c, flag_z, flag_n, flag_c, flag_v, illegal}, {1'b1, tbl[i].exp});
            end
            @(posedge clk); #1;
        end
        // A legal op afterwards must clear illegal again.
        issue(4'b0010, 32'h1, 32'h0, 5'd0);
        checks++;
        if ({c, illegal} !== {32'h1, 1'b0}) begin
            errors++;
            $display("FAIL illegal_clear: got %h expected %h", {c, illegal}, {32'h1, 1'b0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
`ifdef OBSIDIAN_ALU_MUL_EN
        vec_t tbl [4] = '{
            '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, {32'hFFFF_FFFE, 5'b01000}},
            '{4'b1010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, {32'h0000_0001, 5'b00000}},
            '{4'b1001, 32'h1234_5678, 32'h0000_0010, 5'd0, {32'h2345_6780, 5'b00000}},
            '{4'b1010, 32'h1234_5678, 32'h0000_0010, 5'd0, {32'h0000_0001, 5'b00000}}
        };
        int n;
        int ir_bad;
        for (int i = 0; i < 4; i++) begin
            issue(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].sh);
            a           = 32'hDEAD_BEEF;
            b           = 32'h0BAD_F00D;
            alu_control = 4'b0000;
            n           = 0;
            ir_bad      = 0;
            while (out_valid !== 1'b1 && n < 100) begin
                if (in_ready !== 1'b0) ir_bad++;
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != 33) begin
                errors++;
                $display("FAIL mul_latency[%0d]: got %0d edges expected 33", i, n);
            end
            checks++;
            if (ir_bad != 0) begin
                errors++;
                $display("FAIL mul_in_ready[%0d]: got %0d ready cycles expected 0", i, ir_bad);
            end
            checks++;
            if ({c, flag_z, flag_n, flag_c, flag_v, illegal} !== tbl[i].exp) begin
                errors++;
                $display("FAIL mul_result[%0d]: got %h expected %h", i,
                         {c, flag_z, flag_n, flag_c, flag_v, illegal}, tbl[i].exp);
            end
            @(posedge clk); #1;
        end
`else
        issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0);
        checks++;
        if ({out_valid, c, flag_z, illegal} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mul_disabled: got %h expected %h",
                     {out_valid, c, flag_z, illegal}, {1'b1, 32'h0, 1'b1, 1'b1});
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [3] = '{32'h3, 32'hC, 32'h30};
        cap_q.delete();
        cap_en    = 1'b1;
        out_ready = 1'b1;
        alu_control = 4'b0010;
        a = 32'h1; b = 32'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = 32'h4; b = 32'h8;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, c} !== {1'b0, 1'b1, 32'h3}) begin
            errors++;
            $display("FAIL stall_state: got %h expected %h", {in_ready, out_valid, c}, {1'b0, 1'b1, 32'h3});
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, c} !== {1'b1, 32'h3}) begin
            errors++;
            $display("FAIL stall_hold: got %h expected %h", {out_valid, c}, {1'b1, 32'h3});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = 32'h10; b = 32'h20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid: got %b expected 0", out_valid);
        end
        cap_en = 1'b0;
        checks++;
        if (cap_q.size() != 3) begin
            errors++;
            $display("FAIL delivered_count: got %0d expected 3", cap_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cap_q.size()) begin
                errors++;
                $display("FAIL delivered[%0d]: got none expected %h", i, exp_q[i]);
            end else if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL delivered[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_addsub();
        test_shift_logic();
        test_reserved();
        test_mul();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
